line_fill_responder: RTL and testbench
======================================

Name: line_fill_responder

Overview:
- Backing-memory responder on the miss side of the set-associative cache.
- Serves line-fill reads and dirty-line writebacks issued by the cache controller.
- Returns or absorbs one full cache line as a multi-beat burst after a programmable access latency.
- Used as the lower-level memory model in trace-driven hit/miss simulations; keeps its own request counter for miss statistics.

Parameters:
- ADDR_W, 32, byte-address width; matches the cache address length.
- OFFSET_W, 4, log2 of line size in bytes; matches the cache offset length.
- DATA_W, 32, beat width in bits (4 bytes per beat).
- MEM_AW, 12, log2 of memory depth in DATA_W words.
- LATENCY, 4, idle cycles between end of request/data phase and first response beat; 0 is legal.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = writeback, 0 = line fill.
- req_addr  in  ADDR_W  line address; low OFFSET_W bits are ignored.
- wdata_valid  in  1  writeback beat present.
- wdata_ready  out  1  writeback beat accepted this cycle when valid.
- wdata  in  DATA_W  writeback beat data, lowest word first.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  cache accepts the response beat.
- rsp_data  out  DATA_W  fill data; 0 on a write acknowledge.
- rsp_last  out  1  final beat of the response.
- rsp_is_write  out  1  beat is a writeback acknowledge.
- busy  out  1  FSM is not in IDLE.
- req_count  out  32  number of accepted requests; wraps modulo 2^32.

Behaviour:
- Beat count is BEATS = 2^(OFFSET_W-2).
- Beat i targets word address ((req_addr >> 2) & ~(BEATS-1)) + i, taken modulo 2^MEM_AW.
- Memory array is zero at time 0. rst does not clear it.
- Reset:
  - FSM goes to IDLE.
  - req_ready=1; wdata_ready=0; rsp_valid=0; rsp_data=0; rsp_last=0; rsp_is_write=0; busy=0; req_count=0.
  - A reset mid-burst abandons the transaction. Writebacks already written stay written.
- FSM states: IDLE, WDATA, WAIT, RDATA, WACK.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch the base word address and req_write, and increment req_count.
  - Next state is WDATA if write. For a read, next state is WAIT if LATENCY>0, else RDATA.
- WDATA:
  - wdata_ready=1.
  - On each wdata handshake, write memory at beat index and increment the beat index.
  - After beat BEATS-1, go to WAIT if LATENCY>0, else WACK.
  - Gaps in wdata_valid are allowed.
- WAIT:
  - Down-counter loaded with LATENCY on entry.
  - Exits after exactly LATENCY cycles in WAIT, to RDATA (read) or WACK (write).
- RDATA:
  - rsp_valid=1, rsp_data=mem[beat address] registered, rsp_is_write=0, rsp_last=(beat==BEATS-1).
  - The beat advances only on rsp_valid&&rsp_ready. Outputs stay stable while stalled.
  - After the last handshake: IDLE, with rsp_valid=0 the next cycle.
- WACK:
  - rsp_valid=1, rsp_last=1, rsp_is_write=1, rsp_data=0.
  - On rsp_ready go to IDLE.
- Timing:
  - A read accepted at cycle T shows its first rsp_valid at T+1+LATENCY.
  - With rsp_ready held high, beats follow back to back; the last beat is at T+LATENCY+BEATS.
  - A write whose last data beat is at cycle D shows its ack at D+1+LATENCY.
- busy=1 in every state except IDLE.
- Only one outstanding transaction; no new request is accepted until the response completes.
- A read following a write to the same line returns the written data.
- Word-address wrap at the top of memory is modulo; a line is never split across the wrap because base addresses are line-aligned.

Test Plan:
- Reset values: assert rst 2 cycles, then idle. Expect req_ready=1, rsp_valid=0, busy=0, req_count=0.
- Fill from zeroed memory: read addr 0x0000_0040, LATENCY=4, BEATS=4, rsp_ready=1, request at cycle T.
  - Expect rsp_valid at T+5..T+8.
  - Expect data 0,0,0,0, with rsp_last only at T+8.
- Writeback then fill: write line 0x80 with beats 0xA0,0xA1,0xA2,0xA3.
  - Expect one ack beat (rsp_is_write=1, rsp_last=1) at D+5.
  - A read of 0x8C then returns 0xA0..0xA3 in order.
  - Expect req_count=2.
- Backpressure: during a fill, drop rsp_ready for 3 cycles on beat 1.
  - Expect rsp_data held at beat 1 and no beat skipped or repeated.
  - Expect rsp_last still on the fourth handshake.
- LATENCY=0 and a wdata gap: a read shows its first beat at T+1.
  - For a write with wdata_valid low for 2 cycles mid-burst: wdata_ready stays high, all 4 beats are stored, and the ack follows the last beat by 1 cycle.
- Reset mid-fill: assert rst during beat 2 of a fill.
  - Expect rsp_valid=0 next cycle, IDLE, and req_count=0.
  - A new request is accepted immediately, and earlier written memory is retained.

Source files
------------

// File: rtl/line_fill_responder.sv
// Backing-memory responder for cache line fills and dirty-line writebacks.
// Serves one line per request as a multi-beat burst after a fixed access latency.
module line_fill_responder #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_AW   = 12,
  parameter int unsigned LATENCY  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_is_write,
  output logic              busy,
  output logic [31:0]       req_count
);

  localparam int unsigned BEAT_W = OFFSET_W - 2;
  localparam int unsigned BEATS  = 1 << BEAT_W;
  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(LATENCY);
  localparam bit HAS_WAIT = (LATENCY > 0);

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WAIT, S_RDATA, S_WACK} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state, w_state_nxt;
  logic [MEM_AW-1:0] r_base, w_base_nxt;
  logic              r_write, w_write_nxt;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [31:0]       r_req_count, w_req_count_nxt;

  logic              r_req_ready, w_req_ready_nxt;
  logic              r_wdata_ready, w_wdata_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_last, w_rsp_last_nxt;
  logic              r_rsp_is_write, w_rsp_is_write_nxt;
  logic              r_busy, w_busy_nxt;

  logic              w_req_fire, w_wr_fire, w_rsp_fire;
  logic [MEM_AW-1:0] w_wr_addr, w_rd_addr;

  assign w_req_fire = req_valid && r_req_ready;
  assign w_wr_fire  = wdata_valid && r_wdata_ready;
  assign w_rsp_fire = r_rsp_valid && rsp_ready;
  assign w_wr_addr  = r_base + MEM_AW'(r_beat);
  // Read address looks ahead so rsp_data is registered alongside the beat it belongs to.
  assign w_rd_addr  = w_base_nxt + MEM_AW'(w_beat_nxt);

  always_comb begin
    w_state_nxt     = r_state;
    w_base_nxt      = r_base;
    w_write_nxt     = r_write;
    w_beat_nxt      = r_beat;
    w_cnt_nxt       = r_cnt;
    w_req_count_nxt = r_req_count;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          w_base_nxt      = {req_addr[MEM_AW+1:OFFSET_W], {BEAT_W{1'b0}}};
          w_write_nxt     = req_write;
          w_beat_nxt      = '0;
          w_req_count_nxt = r_req_count + 32'd1;
          if (req_write) begin
            w_state_nxt = S_WDATA;
          end else if (HAS_WAIT) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LAT_LOAD;
          end else begin
            w_state_nxt = S_RDATA;
          end
        end
      end
      S_WDATA: begin
        if (w_wr_fire) begin
          w_beat_nxt = r_beat + BEAT_W'(1);
          if (r_beat == LAST_BEAT) begin
            if (HAS_WAIT) begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = LAT_LOAD;
            end else begin
              w_state_nxt = S_WACK;
            end
          end
        end
      end
      S_WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = r_write ? S_WACK : S_RDATA;
          w_beat_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RDATA: begin
        if (w_rsp_fire) begin
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end
      end
      S_WACK: begin
        if (w_rsp_fire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Output values for the coming cycle, decoded from the next state.
    w_req_ready_nxt    = (w_state_nxt == S_IDLE);
    w_wdata_ready_nxt  = (w_state_nxt == S_WDATA);
    w_rsp_valid_nxt    = (w_state_nxt == S_RDATA) || (w_state_nxt == S_WACK);
    w_rsp_is_write_nxt = (w_state_nxt == S_WACK);
    w_rsp_last_nxt     = (w_state_nxt == S_WACK) ||
                         ((w_state_nxt == S_RDATA) && (w_beat_nxt == LAST_BEAT));
    w_rsp_data_nxt     = (w_state_nxt == S_RDATA) ? r_mem[w_rd_addr] : '0;
    w_busy_nxt         = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_write        <= 1'b0;
      r_beat         <= '0;
      r_cnt          <= '0;
      r_req_count    <= '0;
      r_req_ready    <= 1'b1;
      r_wdata_ready  <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_last     <= 1'b0;
      r_rsp_is_write <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_base         <= w_base_nxt;
      r_write        <= w_write_nxt;
      r_beat         <= w_beat_nxt;
      r_cnt          <= w_cnt_nxt;
      r_req_count    <= w_req_count_nxt;
      r_req_ready    <= w_req_ready_nxt;
      r_wdata_ready  <= w_wdata_ready_nxt;
      r_rsp_valid    <= w_rsp_valid_nxt;
      r_rsp_data     <= w_rsp_data_nxt;
      r_rsp_last     <= w_rsp_last_nxt;
      r_rsp_is_write <= w_rsp_is_write_nxt;
      r_busy         <= w_busy_nxt;
    end
  end

  // Memory contents survive reset; only an in-flight burst is abandoned.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_fire) r_mem[w_wr_addr] <= wdata;
  end

  assign req_ready    = r_req_ready;
  assign wdata_ready  = r_wdata_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_last     = r_rsp_last;
  assign rsp_is_write = r_rsp_is_write;
  assign busy         = r_busy;
  assign req_count    = r_req_count;

endmodule

// File: tb/tb_line_fill_responder.sv
// Self-checking bench for line_fill_responder: one instance at LATENCY=4, one at LATENCY=0,
// response beats checked against a scoreboard fed from a bench-side memory model.
module tb_line_fill_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, req_write, wdata_valid, wdata_ready;
  logic [1:0]       rsp_valid, rsp_ready, rsp_last, rsp_is_write, busy;
  logic [1:0][31:0] req_addr, wdata, rsp_data, req_count;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_cnt [2];
  always @(posedge clk) cyc <= cyc + 1;

  line_fill_responder #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
    .wdata_valid(wdata_valid[0]), .wdata_ready(wdata_ready[0]), .wdata(wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_last(rsp_last[0]),
    .rsp_is_write(rsp_is_write[0]), .busy(busy[0]), .req_count(req_count[0])
  );

  line_fill_responder #(.LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
    .wdata_valid(wdata_valid[1]), .wdata_ready(wdata_ready[1]), .wdata(wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_last(rsp_last[1]),
    .rsp_is_write(rsp_is_write[1]), .busy(busy[1]), .req_count(req_count[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        wr;
    int          cyc;
  } exp_t;

  exp_t        sbq [2][$];
  logic [31:0] mdl [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a, input int i);
    return int'((((a >> 2) & ~32'd3) + 32'(i)) & 32'd4095);
  endfunction

  function automatic int key_of(input int d, input int w);
    return d * 65536 + w;
  endfunction

  function automatic logic [31:0] mdl_rd(input int d, input logic [31:0] a, input int i);
    int k;
    k = key_of(d, word_of(a, i));
    return mdl.exists(k) ? mdl[k] : 32'd0;
  endfunction

  // Pops one expected beat per response handshake.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst && rsp_valid[d] && rsp_ready[d]) begin
        if (sbq[d].size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_beat dut=%0d observed data=%h expected no beat", d, rsp_data[d]);
        end else begin
          e = sbq[d].pop_front();
          chk("rsp_data", rsp_data[d], e.data);
          chk("rsp_last", 32'(rsp_last[d]), 32'(e.last));
          chk("rsp_is_write", 32'(rsp_is_write[d]), 32'(e.wr));
          if (e.cyc >= 0) chk("beat_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic request(input int d, input logic wr, input logic [31:0] addr, output int t);
    int k;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    k = 0;
    @(negedge clk);
    while (!req_ready[d] && k < 50) begin @(negedge clk); k++; end
    chk("req_accept", 32'(req_ready[d]), 32'd1);
    t = cyc;
    exp_cnt[d]++;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic send_beats(input int d, input logic [31:0] addr, input logic [31:0] base_val,
                            input int gap_before, input int gap_len, output int dl);
    int k;
    for (int i = 0; i < 4; i++) begin
      if (i == gap_before) begin
        for (int g = 0; g < gap_len; g++) begin
          wdata_valid[d] = 1'b0;
          @(negedge clk);
          chk("wdata_ready_gap", 32'(wdata_ready[d]), 32'd1);
          @(posedge clk); #1;
        end
      end
      wdata_valid[d] = 1'b1;
      wdata[d]       = base_val + 32'(i);
      mdl[key_of(d, word_of(addr, i))] = base_val + 32'(i);
      k = 0;
      @(negedge clk);
      while (!wdata_ready[d] && k < 50) begin @(negedge clk); k++; end
      chk("wdata_accept", 32'(wdata_ready[d]), 32'd1);
      dl = cyc;
      @(posedge clk); #1;
    end
    wdata_valid[d] = 1'b0;
  endtask

  task automatic expect_fill(input int d, input logic [31:0] addr, input int first,
                             input int stall_beat, input int stall_len, input int nbeats);
    exp_t e;
    for (int i = 0; i < nbeats; i++) begin
      e.data = mdl_rd(d, addr, i);
      e.last = (i == 3);
      e.wr   = 1'b0;
      e.cyc  = first + i + ((i >= stall_beat) ? stall_len : 0);
      sbq[d].push_back(e);
    end
  endtask

  task automatic expect_ack(input int d, input int c);
    exp_t e;
    e.data = 32'd0;
    e.last = 1'b1;
    e.wr   = 1'b1;
    e.cyc  = c;
    sbq[d].push_back(e);
  endtask

  task automatic wait_drain(input int d);
    int k;
    k = 0;
    while (sbq[d].size() != 0 && k < 100) begin @(posedge clk); k++; end
    #1;
    chk("drain", 32'(sbq[d].size()), 32'd0);
    @(negedge clk);
    chk("idle_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk("idle_busy", 32'(busy[d]), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    int dl;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    wdata_valid = '0;
    wdata       = '0;
    rsp_ready   = '1;
    exp_cnt     = '{0, 0};

    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_wdata_ready", 32'(wdata_ready[d]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rsp_data", rsp_data[d], 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_req_count", req_count[d], 32'd0);
    end
    @(posedge clk); #1;

    // Fill from zeroed memory, LATENCY=4
    request(0, 1'b0, 32'h0000_0040, t);
    expect_fill(0, 32'h40, t + 5, 4, 0, 4);
    wait_drain(0);

    // Writeback then fill of the same line
    request(0, 1'b1, 32'h0000_0080, t);
    send_beats(0, 32'h80, 32'hA0, 4, 0, dl);
    expect_ack(0, dl + 5);
    wait_drain(0);
    request(0, 1'b0, 32'h0000_008C, t);
    expect_fill(0, 32'h8C, t + 5, 4, 0, 4);
    wait_drain(0);
    chk("req_count_after_wb", req_count[0], 32'(exp_cnt[0]));

    // Backpressure on beat 1 for 3 cycles
    request(0, 1'b1, 32'h0000_0100, t);
    send_beats(0, 32'h100, 32'h10, 4, 0, dl);
    expect_ack(0, dl + 5);
    wait_drain(0);
    request(0, 1'b0, 32'h0000_0104, t);
    expect_fill(0, 32'h104, t + 5, 1, 3, 4);
    while (cyc < t + 6) begin @(posedge clk); #1; end
    rsp_ready[0] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid[0]), 32'd1);
      chk("stall_data", rsp_data[0], 32'h11);
      chk("stall_last", 32'(rsp_last[0]), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    wait_drain(0);

    // LATENCY=0: read, write with a 2-cycle wdata gap, read back
    request(1, 1'b0, 32'h0000_0040, t);
    expect_fill(1, 32'h40, t + 1, 4, 0, 4);
    wait_drain(1);
    request(1, 1'b1, 32'h0000_0200, t);
    send_beats(1, 32'h200, 32'hB0, 2, 2, dl);
    expect_ack(1, dl + 1);
    wait_drain(1);
    request(1, 1'b0, 32'h0000_0208, t);
    expect_fill(1, 32'h208, t + 1, 4, 0, 4);
    wait_drain(1);
    chk("req_count_lat0", req_count[1], 32'(exp_cnt[1]));

    // Reset during beat 2 of a fill
    request(0, 1'b0, 32'h0000_0080, t);
    expect_fill(0, 32'h80, t + 5, 4, 0, 2);
    while (cyc < t + 7) begin @(posedge clk); #1; end
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(rsp_valid[0]), 32'd1);
    chk("pre_rst_data", rsp_data[0], 32'hA2);
    chk("pre_rst_drained", 32'(sbq[0].size()), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_cnt = '{0, 0};
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("mid_rst_req_count", req_count[0], 32'd0);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    request(0, 1'b0, 32'h0000_0080, t);
    expect_fill(0, 32'h80, t + 5, 4, 0, 4);
    wait_drain(0);
    request(0, 1'b0, 32'h0000_0100, t);
    expect_fill(0, 32'h100, t + 5, 4, 0, 4);
    wait_drain(0);
    chk("post_rst_req_count", req_count[0], 32'(exp_cnt[0]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
